// File: rtl/syncram_pkg.sv
// Shared types and helpers for the dual-port pipelined RAM.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package syncram_pkg;

    // Read-during-write behaviour.
    typedef enum logic {
        NEW_DATA = 1'b0,
        OLD_DATA = 1'b1
    } rdw_mode_e;

    // Clear-engine sequencing.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } init_state_e;

    // merge_be works on a fixed wide word; callers zero-extend and truncate.
    // MAX_BE equals MAX_W so that BYTE_SIZE=1 is still representable.
    localparam int MAX_W  = 1024;
    localparam int MAX_BE = MAX_W;
    localparam int MAX_AW = $clog2(MAX_W);

    // Unknown strings fall back to NEW_DATA; the top rejects them at elaboration.
    function automatic rdw_mode_e rdw_mode_from_str(input string s);
        return (s == "OLD_DATA") ? OLD_DATA : NEW_DATA;
    endfunction

    // Lanes with be set take new_w, all others keep old_w.
    function automatic logic [MAX_W-1:0] merge_be(
        input logic [MAX_W-1:0]  old_w,
        input logic [MAX_W-1:0]  new_w,
        input logic [MAX_BE-1:0] be,
        input int                byte_size
    );
        logic [MAX_W-1:0] res;
        res = old_w;
        for (int k = 0; k < MAX_W; k++) begin
            if (be[MAX_AW'(k / byte_size)]) begin
                res[MAX_AW'(k)] = new_w[MAX_AW'(k)];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/syncram_rd_pipe.sv
// Read-return shift stage: carries read data and its valid flag LATENCY cycles.
// Latency: LATENCY cycles from in_vld to out_vld.
// Backpressure: none; every accepted read emerges exactly once, out_dat holds between reads.
// Ports: clock0/aclr0_n clock and async active-low reset; in_vld/in_dat stage-0 input;
//        out_vld/out_dat last-stage output.
module syncram_rd_pipe #(
    parameter int WIDTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic             clock0,
    input  logic             aclr0_n,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_dat
);

    logic [LATENCY-1:0] vld_r;
    logic [WIDTH-1:0]   dat_r [LATENCY];

    // Data stages only load behind a valid, so the last stage holds its value
    // until the next read lands.
    always_ff @(posedge clock0 or negedge aclr0_n) begin
        if (!aclr0_n) begin
            vld_r <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_r[i] <= '0;
            end
        end else begin
            vld_r[0] <= in_vld;
            if (in_vld) begin
                dat_r[0] <= in_dat;
            end
            for (int i = 1; i < LATENCY; i++) begin
                vld_r[i] <= vld_r[i-1];
                if (vld_r[i-1]) begin
                    dat_r[i] <= dat_r[i-1];
                end
            end
        end
    end

    assign out_vld = vld_r[LATENCY-1];
    assign out_dat = dat_r[LATENCY-1];

endmodule

// File: rtl/syncram_dp_pipe.sv
// True dual-port RAM with byte enables, deterministic collisions and a zero-fill clear engine.
// Latency: RD_LATENCY cycles request to q_x/q_valid_x; a write is visible to a read one cycle later.
// Backpressure: none; while busy (clear running) user reads/writes/init_req are dropped.
// Ports: clock0, aclr0_n; init_req/busy clear control; per port x in {a,b}: wren_x, rden_x,
//        address_x, data_x, byteena_x in; q_x, q_valid_x out.
module syncram_dp_pipe
    import syncram_pkg::*;
#(
    parameter int              WIDTH          = 64,
    parameter int              DEPTH          = 512,
    parameter int              BYTE_SIZE      = 8,
    parameter int              RD_LATENCY     = 2,
    parameter string           RDW_MODE       = "NEW_DATA",
    parameter string           MIXED_RDW_MODE = "OLD_DATA",
    parameter bit              INIT_ON_RESET  = 1'b1,
    parameter logic [WIDTH-1:0] INIT_VALUE    = '0,
    parameter int              ADDR_W         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int              BE_W           = WIDTH / BYTE_SIZE
) (
    input  logic              clock0,
    input  logic              aclr0_n,
    input  logic              init_req,
    output logic              busy,
    input  logic              wren_a,
    input  logic              rden_a,
    input  logic [ADDR_W-1:0] address_a,
    input  logic [WIDTH-1:0]  data_a,
    input  logic [BE_W-1:0]   byteena_a,
    output logic [WIDTH-1:0]  q_a,
    output logic              q_valid_a,
    input  logic              wren_b,
    input  logic              rden_b,
    input  logic [ADDR_W-1:0] address_b,
    input  logic [WIDTH-1:0]  data_b,
    input  logic [BE_W-1:0]   byteena_b,
    output logic [WIDTH-1:0]  q_b,
    output logic              q_valid_b
);

    // Parameter legality, checked at elaboration.
    if (WIDTH % BYTE_SIZE != 0) begin : g_err_width
        $error("WIDTH must be a multiple of BYTE_SIZE");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_err_lat
        $error("RD_LATENCY must be 1..3");
    end
    if (WIDTH > MAX_W) begin : g_err_max
        $error("WIDTH exceeds merge helper width");
    end
    if (RDW_MODE != "NEW_DATA" && RDW_MODE != "OLD_DATA") begin : g_err_rdw
        $error("RDW_MODE must be NEW_DATA or OLD_DATA");
    end
    if (MIXED_RDW_MODE != "NEW_DATA" && MIXED_RDW_MODE != "OLD_DATA") begin : g_err_mix
        $error("MIXED_RDW_MODE must be NEW_DATA or OLD_DATA");
    end

    localparam rdw_mode_e         SAME_MODE = rdw_mode_from_str(RDW_MODE);
    localparam rdw_mode_e         MIX_MODE  = rdw_mode_from_str(MIXED_RDW_MODE);
    // One extra bit so the range check works when DEPTH is a power of two.
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    function automatic logic [WIDTH-1:0] mrg(
        input logic [WIDTH-1:0] o,
        input logic [WIDTH-1:0] n,
        input logic [BE_W-1:0]  be
    );
        return WIDTH'(merge_be(MAX_W'(o), MAX_W'(n), MAX_BE'(be), BYTE_SIZE));
    endfunction

    logic [WIDTH-1:0]  mem [DEPTH];
    init_state_e       state_r, state_nxt;
    logic [ADDR_W-1:0] clr_cnt_r;
    logic              clr_go;
    logic              in_rng_a, in_rng_b;
    logic              wr_go_a, wr_go_b, rd_go_a, rd_go_b;
    logic [WIDTH-1:0]  rdat_a, rdat_b;

    // ---------------- clear engine ----------------
    always_ff @(posedge clock0 or negedge aclr0_n) begin
        if (!aclr0_n) begin
            state_r   <= INIT_ON_RESET ? CLEAR : IDLE;
            clr_cnt_r <= '0;
        end else begin
            state_r <= state_nxt;
            if (state_r == CLEAR) begin
                clr_cnt_r <= (clr_cnt_r == LAST_ADDR) ? '0 : clr_cnt_r + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE:    if (init_req) state_nxt = CLEAR;
            CLEAR:   if (clr_cnt_r == LAST_ADDR) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy   = (state_r != IDLE);
    assign clr_go = (state_r == CLEAR);

    // ---------------- user access qualification ----------------
    assign in_rng_a = {1'b0, address_a} < DEPTH_X;
    assign in_rng_b = {1'b0, address_b} < DEPTH_X;
    assign wr_go_a  = wren_a && !busy && in_rng_a;
    assign wr_go_b  = wren_b && !busy && in_rng_b;
    assign rd_go_a  = rden_a && !busy;
    assign rd_go_b  = rden_b && !busy;

    // ---------------- array write ----------------
    // Port B lanes are scheduled before port A lanes, so on a shared address
    // the later non-blocking update from A wins every lane A enables.
    always_ff @(posedge clock0) begin
        if (clr_go) begin
            mem[clr_cnt_r] <= INIT_VALUE;
        end
        for (int i = 0; i < BE_W; i++) begin
            if (wr_go_b && byteena_b[i]) begin
                mem[address_b][i*BYTE_SIZE +: BYTE_SIZE] <= data_b[i*BYTE_SIZE +: BYTE_SIZE];
            end
            if (wr_go_a && byteena_a[i]) begin
                mem[address_a][i*BYTE_SIZE +: BYTE_SIZE] <= data_a[i*BYTE_SIZE +: BYTE_SIZE];
            end
        end
    end

    // ---------------- read data with read-during-write forwarding ----------------
    // Merges are applied lowest priority first (B, then A) so the forwarded
    // word matches what the array will hold after the collision resolves.
    always_comb begin
        rdat_a = in_rng_a ? mem[address_a] : '0;
        if (MIX_MODE == NEW_DATA && wr_go_b && address_b == address_a) begin
            rdat_a = mrg(rdat_a, data_b, byteena_b);
        end
        if (SAME_MODE == NEW_DATA && wr_go_a) begin
            rdat_a = mrg(rdat_a, data_a, byteena_a);
        end
    end

    always_comb begin
        rdat_b = in_rng_b ? mem[address_b] : '0;
        if (SAME_MODE == NEW_DATA && wr_go_b) begin
            rdat_b = mrg(rdat_b, data_b, byteena_b);
        end
        if (MIX_MODE == NEW_DATA && wr_go_a && address_a == address_b) begin
            rdat_b = mrg(rdat_b, data_a, byteena_a);
        end
    end

    syncram_rd_pipe #(.WIDTH(WIDTH), .LATENCY(RD_LATENCY)) u_rd_pipe_a (
        .clock0  (clock0),
        .aclr0_n (aclr0_n),
        .in_vld  (rd_go_a),
        .in_dat  (rdat_a),
        .out_vld (q_valid_a),
        .out_dat (q_a)
    );

    syncram_rd_pipe #(.WIDTH(WIDTH), .LATENCY(RD_LATENCY)) u_rd_pipe_b (
        .clock0  (clock0),
        .aclr0_n (aclr0_n),
        .in_vld  (rd_go_b),
        .in_dat  (rdat_b),
        .out_vld (q_valid_b),
        .out_dat (q_b)
    );

endmodule

// File: tb/tb_syncram_dp_pipe.sv
// Directed bench for syncram_dp_pipe: a default instance (64b x 512, latency 2,
// same-port NEW / cross-port OLD, auto clear) and a small one (32b x 12, latency 3,
// same-port OLD / cross-port NEW, no auto clear, fill 0xDEADBEEF).
module tb_syncram_dp_pipe;

    logic clock0 = 1'b0;
    always #5 clock0 = ~clock0;
    logic aclr0_n;

    // default instance
    logic        init_req, busy;
    logic        wren_a, rden_a, wren_b, rden_b;
    logic [8:0]  address_a, address_b;
    logic [63:0] data_a, data_b, q_a, q_b;
    logic [7:0]  byteena_a, byteena_b;
    logic        q_valid_a, q_valid_b;

    // small instance
    logic        u2_init_req, u2_busy;
    logic        u2_wren_a, u2_rden_a, u2_wren_b, u2_rden_b;
    logic [3:0]  u2_address_a, u2_address_b;
    logic [31:0] u2_data_a, u2_data_b, u2_q_a, u2_q_b;
    logic [3:0]  u2_byteena_a, u2_byteena_b;
    logic        u2_q_valid_a, u2_q_valid_b;

    syncram_dp_pipe u_dut (
        .clock0(clock0), .aclr0_n(aclr0_n), .init_req(init_req), .busy(busy),
        .wren_a(wren_a), .rden_a(rden_a), .address_a(address_a), .data_a(data_a),
        .byteena_a(byteena_a), .q_a(q_a), .q_valid_a(q_valid_a),
        .wren_b(wren_b), .rden_b(rden_b), .address_b(address_b), .data_b(data_b),
        .byteena_b(byteena_b), .q_b(q_b), .q_valid_b(q_valid_b)
    );

    syncram_dp_pipe #(
        .WIDTH(32), .DEPTH(12), .BYTE_SIZE(8), .RD_LATENCY(3),
        .RDW_MODE("OLD_DATA"), .MIXED_RDW_MODE("NEW_DATA"),
        .INIT_ON_RESET(1'b0), .INIT_VALUE(32'hDEAD_BEEF)
    ) u_dut2 (
        .clock0(clock0), .aclr0_n(aclr0_n), .init_req(u2_init_req), .busy(u2_busy),
        .wren_a(u2_wren_a), .rden_a(u2_rden_a), .address_a(u2_address_a), .data_a(u2_data_a),
        .byteena_a(u2_byteena_a), .q_a(u2_q_a), .q_valid_a(u2_q_valid_a),
        .wren_b(u2_wren_b), .rden_b(u2_rden_b), .address_b(u2_address_b), .data_b(u2_data_b),
        .byteena_b(u2_byteena_b), .q_b(u2_q_b), .q_valid_b(u2_q_valid_b)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock0);
        #1;
    endtask

    task automatic wr_a(input logic [8:0] a, input logic [63:0] d, input logic [7:0] be);
        address_a = a; data_a = d; byteena_a = be; wren_a = 1'b1;
        tick;
        wren_a = 1'b0;
    endtask

    task automatic rd_a(input logic [8:0] a, input logic [63:0] exp, input string name);
        address_a = a; rden_a = 1'b1;
        tick;
        rden_a = 1'b0;
        chk({name, "_early"}, 64'(q_valid_a), 64'd0);
        tick;
        chk({name, "_vld"}, 64'(q_valid_a), 64'd1);
        chk(name, q_a, exp);
    endtask

    task automatic rd_b(input logic [8:0] a, input logic [63:0] exp, input string name);
        address_b = a; rden_b = 1'b1;
        tick;
        rden_b = 1'b0;
        tick;
        chk({name, "_vld"}, 64'(q_valid_b), 64'd1);
        chk(name, q_b, exp);
    endtask

    task automatic wr2_b(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        u2_address_b = a; u2_data_b = d; u2_byteena_b = be; u2_wren_b = 1'b1;
        tick;
        u2_wren_b = 1'b0;
    endtask

    task automatic rd2_b(input logic [3:0] a, input logic [31:0] exp, input string name);
        u2_address_b = a; u2_rden_b = 1'b1;
        tick;
        u2_rden_b = 1'b0;
        tick;
        chk({name, "_early"}, 64'(u2_q_valid_b), 64'd0);
        tick;
        chk({name, "_vld"}, 64'(u2_q_valid_b), 64'd1);
        chk(name, 64'(u2_q_b), 64'(exp));
    endtask

    typedef struct {
        logic [8:0]  addr;
        logic [63:0] prior;
        logic [63:0] data;
        logic [7:0]  be;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl [5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  n;
        bit  saw;

        tbl[0] = '{9'd5,   64'hFFFF_FFFF_FFFF_FFFF, 64'h1122_3344_5566_7788, 8'h0F, 64'hFFFF_FFFF_5566_7788};
        tbl[1] = '{9'd6,   64'h0,                   64'h1122_3344_5566_7788, 8'hF0, 64'h1122_3344_0000_0000};
        tbl[2] = '{9'd511, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 8'h81, 64'hFE23_4567_89AB_CD10};
        tbl[3] = '{9'd0,   64'hA5A5_A5A5_A5A5_A5A5, 64'h0,                   8'h00, 64'hA5A5_A5A5_A5A5_A5A5};
        tbl[4] = '{9'd100, 64'h0,                   64'hDEAD_BEEF_CAFE_F00D, 8'hAA, 64'hDE00_BE00_CA00_F000};

        aclr0_n = 1'b0;
        init_req = 0; wren_a = 0; rden_a = 0; wren_b = 0; rden_b = 0;
        address_a = '0; address_b = '0; data_a = '0; data_b = '0; byteena_a = '0; byteena_b = '0;
        u2_init_req = 0; u2_wren_a = 0; u2_rden_a = 0; u2_wren_b = 0; u2_rden_b = 0;
        u2_address_a = '0; u2_address_b = '0; u2_data_a = '0; u2_data_b = '0;
        u2_byteena_a = '0; u2_byteena_b = '0;

        // ---- reset state ----
        repeat (3) tick;
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_q_a", q_a, 64'd0);
        chk("rst_qv_a", 64'(q_valid_a), 64'd0);
        chk("rst_q_b", q_b, 64'd0);
        chk("rst_qv_b", 64'(q_valid_b), 64'd0);
        chk("rst_busy2", 64'(u2_busy), 64'd0);

        // ---- power-on clear: 512 CLEAR + 1 DONE ----
        aclr0_n = 1'b1;
        n = 0;
        while (busy && n < 2000) begin n++; tick; end
        chk("por_busy_cycles", 64'(n), 64'd513);
        rd_a(9'd37, 64'h0, "por_rd37");
        rd_b(9'd511, 64'h0, "por_rd511");

        // ---- byte-enable vectors ----
        for (int i = 0; i < 5; i++) begin
            wr_a(tbl[i].addr, tbl[i].prior, 8'hFF);
            wr_a(tbl[i].addr, tbl[i].data, tbl[i].be);
            rd_a(tbl[i].addr, tbl[i].exp, $sformatf("vec%0d", i));
        end

        // ---- same-address write collision ----
        address_a = 9'd9; data_a = 64'hAAAA_AAAA_AAAA_AAAA; byteena_a = 8'hF0; wren_a = 1'b1;
        address_b = 9'd9; data_b = 64'hBBBB_BBBB_BBBB_BBBB; byteena_b = 8'hFF; wren_b = 1'b1;
        tick;
        wren_a = 1'b0; wren_b = 1'b0;
        rd_a(9'd9, 64'hAAAA_AAAA_BBBB_BBBB, "collide");

        // ---- cross-port OLD_DATA ----
        wr_a(9'd3, 64'h0303_0303_0303_0303, 8'hFF);
        address_a = 9'd3; data_a = 64'h5A5A_5A5A_5A5A_5A5A; byteena_a = 8'hFF; wren_a = 1'b1;
        address_b = 9'd3; rden_b = 1'b1;
        tick;
        wren_a = 1'b0; rden_b = 1'b0;
        tick;
        chk("mix_old_vld", 64'(q_valid_b), 64'd1);
        chk("mix_old", q_b, 64'h0303_0303_0303_0303);
        rd_b(9'd3, 64'h5A5A_5A5A_5A5A_5A5A, "mix_old_next");

        // ---- same-port NEW_DATA ----
        wr_a(9'd4, 64'h4444_4444_4444_4444, 8'hFF);
        address_a = 9'd4; data_a = 64'h1111_1111_1111_1111; byteena_a = 8'h0F;
        wren_a = 1'b1; rden_a = 1'b1;
        tick;
        wren_a = 1'b0; rden_a = 1'b0;
        tick;
        chk("same_new", q_a, 64'h4444_4444_1111_1111);

        // ---- small instance: requested clear with INIT_VALUE ----
        u2_init_req = 1'b1;
        tick;
        u2_init_req = 1'b0;
        n = 0;
        while (u2_busy && n < 200) begin n++; tick; end
        chk("u2_busy_cycles", 64'(n), 64'd13);
        rd2_b(4'd0, 32'hDEAD_BEEF, "u2_clr0");
        rd2_b(4'd11, 32'hDEAD_BEEF, "u2_clr11");

        // ---- latency-3 back-to-back burst ----
        for (int i = 0; i < 8; i++) wr2_b(4'(i), 32'h1000_0000 + 32'(i), 4'hF);
        for (int c = 0; c < 13; c++) begin
            u2_rden_b = (c < 8);
            u2_address_b = 4'(c);
            chk($sformatf("burst_vld%0d", c), 64'(u2_q_valid_b), 64'((c >= 3 && c <= 10) ? 1 : 0));
            if (c >= 3 && c <= 10)
                chk($sformatf("burst_dat%0d", c), 64'(u2_q_b), 64'(32'h1000_0000 + 32'(c - 3)));
            tick;
        end
        u2_rden_b = 1'b0;

        // ---- same-port OLD_DATA ----
        u2_address_b = 4'd2; u2_data_b = 32'hCAFE_F00D; u2_byteena_b = 4'hF;
        u2_wren_b = 1'b1; u2_rden_b = 1'b1;
        tick;
        u2_wren_b = 1'b0; u2_rden_b = 1'b0;
        tick; tick;
        chk("u2_same_old", 64'(u2_q_b), 64'h1000_0002);
        rd2_b(4'd2, 32'hCAFE_F00D, "u2_same_next");

        // ---- cross-port NEW_DATA, partial lanes ----
        u2_address_a = 4'd5; u2_data_a = 32'h5555_5555; u2_byteena_a = 4'h3; u2_wren_a = 1'b1;
        u2_address_b = 4'd5; u2_rden_b = 1'b1;
        tick;
        u2_wren_a = 1'b0; u2_rden_b = 1'b0;
        tick; tick;
        chk("u2_mix_new", 64'(u2_q_b), 64'h1000_5555);

        // ---- out of range ----
        wr2_b(4'd13, 32'h1234_5678, 4'hF);
        rd2_b(4'd13, 32'h0, "u2_oor13");
        rd2_b(4'd12, 32'h0, "u2_oor12");

        // ---- clear with a read in flight, reads dropped while busy ----
        address_a = 9'd9; rden_a = 1'b1; init_req = 1'b1;
        tick;
        rden_a = 1'b0; init_req = 1'b0;
        chk("clr_busy", 64'(busy), 64'd1);
        tick;
        chk("inflight_vld", 64'(q_valid_a), 64'd1);
        chk("inflight", q_a, 64'hAAAA_AAAA_BBBB_BBBB);
        address_a = 9'd5; rden_a = 1'b1;
        tick;
        rden_a = 1'b0;
        tick; tick;
        chk("busy_rd_vld", 64'(q_valid_a), 64'd0);
        chk("busy_q_hold", q_a, 64'hAAAA_AAAA_BBBB_BBBB);
        repeat (96) tick;

        // ---- reset at clear counter 100 ----
        aclr0_n = 1'b0;
        #1;
        chk("midclr_rst_busy", 64'(busy), 64'd1);
        chk("midclr_rst_q", q_a, 64'd0);
        tick; tick;
        aclr0_n = 1'b1;
        n = 0; saw = 1'b0;
        byteena_a = 8'hFF; data_a = 64'h7777_7777_7777_7777;
        while (busy && n < 2000) begin
            wren_a    = (n == 400);
            rden_a    = (n == 420);
            init_req  = (n == 450);
            address_a = (n == 420) ? 9'd9 : 9'd10;
            if (q_valid_a) saw = 1'b1;
            n++;
            tick;
        end
        wren_a = 1'b0; rden_a = 1'b0; init_req = 1'b0;
        chk("restart_busy_cycles", 64'(n), 64'd513);
        chk("restart_no_vld", 64'(saw), 64'd0);
        rd_a(9'd10, 64'h0, "busy_wr_dropped");
        rd_a(9'd100, 64'h0, "restart_clr100");
        rd_a(9'd9, 64'h0, "restart_clr9");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
